// File: rtl/bat_amateur_pkg.sv
// Shared definitions for the BatAmateur boot loader.
//   loader_state_e   : loader FSM state encoding
//   DEF_ADDRESS_WIDTH: default address bus width
//   DEF_DATA_WIDTH   : default data bus width
//   RESET_ADDR       : address the core starts executing from after release
package bat_amateur_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_WRITE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_e;

  localparam int DEF_ADDRESS_WIDTH = 16;
  localparam int DEF_DATA_WIDTH    = 16;

  localparam logic [15:0] RESET_ADDR = 16'h0000;

endpackage

// File: rtl/bat_amateur_loader.sv
// Boot loader in front of the BatAmateur core and its unified memory.
// Holds the core in HALT, writes a stream of (address, data) words into
// memory over the shared buses, then releases the buses and lets the core
// run from RESET_ADDR.
//
// Ports:
//   CLK, RESET              : clock, synchronous active-high reset
//   LOAD_VALID/READY        : upstream word handshake
//   LOAD_ADDR/DATA/LAST     : word target, payload, end-of-image flag
//   REBOOT                  : in RUN, return to LOAD and re-halt the core
//   HALT                    : holds the core stopped
//   ADDRESS_BUS, ADDR_OE    : memory address and its drive enable
//   DATA_BUS, DATA_OE       : write data (Z when not driven) and its enable
//   MEM_WE                  : one-cycle memory write strobe
//   WORD_COUNT, CHECKSUM    : words written / modular sum of written data
//   LOAD_ERR                : sticky out-of-range address error
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_LOAD  | core halted, waiting for a word
// ST_WRITE | registered word on the buses, MEM_WE high (one cycle/word)
// ST_DRAIN | buses idle for one cycle before the core is released
// ST_RUN   | core running, loader off the buses
// ST_ERROR | out-of-range address seen; only RESET leaves
module bat_amateur_loader
  import bat_amateur_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH     = 65536
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     LOAD_VALID,
  output logic                     LOAD_READY,
  input  logic [ADDRESS_WIDTH-1:0] LOAD_ADDR,
  input  logic [DATA_WIDTH-1:0]    LOAD_DATA,
  input  logic                     LOAD_LAST,
  input  logic                     REBOOT,
  output logic                     HALT,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS_BUS,
  output logic                     ADDR_OE,
  output logic [DATA_WIDTH-1:0]    DATA_BUS,
  output logic                     DATA_OE,
  output logic                     MEM_WE,
  output logic [ADDRESS_WIDTH-1:0] WORD_COUNT,
  output logic [DATA_WIDTH-1:0]    CHECKSUM,
  output logic                     LOAD_ERR
);

  // One extra bit so MEM_DEPTH == 2**ADDRESS_WIDTH is representable.
  localparam logic [ADDRESS_WIDTH:0] MEM_DEPTH_W = (ADDRESS_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] IDLE_ADDR = ADDRESS_WIDTH'(RESET_ADDR);

  loader_state_e r_state;
  loader_state_e w_next;

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_last;
  logic [ADDRESS_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0]    r_sum;

  logic w_accept;
  logic w_in_range;

  assign w_accept   = LOAD_VALID & LOAD_READY;
  assign w_in_range = ({1'b0, LOAD_ADDR} < MEM_DEPTH_W);

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_LOAD;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_accept) w_next = w_in_range ? ST_WRITE : ST_ERROR;
      end
      ST_WRITE: begin
        // READY is low while a last word is in WRITE, so no accept competes here.
        if (r_last)        w_next = ST_DRAIN;
        else if (w_accept) w_next = w_in_range ? ST_WRITE : ST_ERROR;
        else               w_next = ST_LOAD;
      end
      ST_DRAIN: w_next = ST_RUN;
      ST_RUN:   if (REBOOT) w_next = ST_LOAD;
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_ERROR;
    endcase
  end

  // Output logic
  always_comb begin
    LOAD_READY  = 1'b0;
    HALT        = 1'b1;
    ADDR_OE     = 1'b1;
    ADDRESS_BUS = IDLE_ADDR;
    DATA_OE     = 1'b0;
    MEM_WE      = 1'b0;
    LOAD_ERR    = 1'b0;
    case (r_state)
      ST_LOAD: LOAD_READY = 1'b1;
      ST_WRITE: begin
        LOAD_READY  = ~r_last;
        ADDRESS_BUS = r_addr;
        DATA_OE     = 1'b1;
        MEM_WE      = 1'b1;
      end
      ST_DRAIN: ;
      ST_RUN: begin
        HALT    = 1'b0;
        ADDR_OE = 1'b0;
      end
      ST_ERROR: LOAD_ERR = 1'b1;
      default:  LOAD_ERR = 1'b1;
    endcase
  end

  assign DATA_BUS   = DATA_OE ? r_data : {DATA_WIDTH{1'bz}};
  assign WORD_COUNT = r_count;
  assign CHECKSUM   = r_sum;

  // Word register and write statistics
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_count <= '0;
      r_sum   <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= LOAD_ADDR;
        r_data <= LOAD_DATA;
        r_last <= LOAD_LAST;
      end
      if (r_state == ST_RUN && REBOOT) begin
        r_count <= '0;
        r_sum   <= '0;
        r_last  <= 1'b0;
      end else if (r_state == ST_WRITE) begin
        r_count <= r_count + 1'b1;
        r_sum   <= r_sum + r_data;
      end
    end
  end

endmodule

// File: tb/tb_bat_amateur_loader.sv
module tb_bat_amateur_loader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        LOAD_VALID;
  logic        LOAD_READY;
  logic [15:0] LOAD_ADDR;
  logic [15:0] LOAD_DATA;
  logic        LOAD_LAST;
  logic        REBOOT;
  logic        HALT;
  logic [15:0] ADDRESS_BUS;
  logic        ADDR_OE;
  logic [15:0] DATA_BUS;
  logic        DATA_OE;
  logic        MEM_WE;
  logic [15:0] WORD_COUNT;
  logic [15:0] CHECKSUM;
  logic        LOAD_ERR;

  int n_checks = 0;
  int n_errors = 0;

  bat_amateur_loader #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .MEM_DEPTH(256)) dut (
    .CLK(CLK), .RESET(RESET),
    .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA), .LOAD_LAST(LOAD_LAST),
    .REBOOT(REBOOT), .HALT(HALT),
    .ADDRESS_BUS(ADDRESS_BUS), .ADDR_OE(ADDR_OE),
    .DATA_BUS(DATA_BUS), .DATA_OE(DATA_OE), .MEM_WE(MEM_WE),
    .WORD_COUNT(WORD_COUNT), .CHECKSUM(CHECKSUM), .LOAD_ERR(LOAD_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid;
    logic [15:0] addr;
    logic [15:0] data;
    logic        we;
    logic [15:0] bus_addr;
    logic [15:0] bus_data;
    logic        ready;
    logic [15:0] count;
    logic [15:0] sum;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1; LOAD_VALID = 1'b0; LOAD_LAST = 1'b0; REBOOT = 1'b0;
    LOAD_ADDR = '0; LOAD_DATA = '0;
    tick(); tick();
    RESET = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] d, input logic l);
    LOAD_VALID = v; LOAD_ADDR = a; LOAD_DATA = d; LOAD_LAST = l;
  endtask

  logic [15:0] prog[12];
  logic [15:0] exp_sum;

  initial begin
    // Back-to-back stream, then gapped stream (valid low 3 cycles between words).
    vecs[0]  = '{1, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'd0, 16'h0000};
    vecs[1]  = '{1, 16'h0011, 16'h0001, 1, 16'h0010, 16'h0000, 1, 16'd0, 16'h0000};
    vecs[2]  = '{1, 16'h0012, 16'h0005, 1, 16'h0011, 16'h0001, 1, 16'd1, 16'h0000};
    vecs[3]  = '{0, 16'h0000, 16'h0000, 1, 16'h0012, 16'h0005, 1, 16'd2, 16'h0001};
    vecs[4]  = '{0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'd3, 16'h0006};
    vecs[5]  = '{1, 16'h0020, 16'h0100, 0, 16'h0000, 16'h0000, 1, 16'd3, 16'h0006};
    vecs[6]  = '{0, 16'h0000, 16'h0000, 1, 16'h0020, 16'h0100, 1, 16'd3, 16'h0006};
    vecs[7]  = '{0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'd4, 16'h0106};
    vecs[8]  = '{0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'd4, 16'h0106};
    vecs[9]  = '{1, 16'h0021, 16'h000A, 0, 16'h0000, 16'h0000, 1, 16'd4, 16'h0106};
    vecs[10] = '{0, 16'h0000, 16'h0000, 1, 16'h0021, 16'h000A, 1, 16'd4, 16'h0106};
    vecs[11] = '{0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'd5, 16'h0110};

    prog = '{16'h0012, 16'h7F98, 16'h1234, 16'h0001, 16'hABCD, 16'h8000,
             16'h00FF, 16'h5555, 16'h0F0F, 16'h2222, 16'hF000, 16'h4FFF};

    // Reset state
    do_reset();
    chk("rst_halt", HALT, 1);
    chk("rst_ready", LOAD_READY, 1);
    chk("rst_we", MEM_WE, 0);
    chk("rst_addr_oe", ADDR_OE, 1);
    chk("rst_data_oe", DATA_OE, 0);
    chk("rst_addr", ADDRESS_BUS, 16'h0000);
    chk("rst_count", WORD_COUNT, 0);
    chk("rst_sum", CHECKSUM, 0);
    chk("rst_err", LOAD_ERR, 0);

    // Table-driven streams
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].valid, vecs[i].addr, vecs[i].data, 1'b0);
      chk($sformatf("v%0d_we", i), MEM_WE, vecs[i].we);
      chk($sformatf("v%0d_addr", i), ADDRESS_BUS, vecs[i].bus_addr);
      chk($sformatf("v%0d_doe", i), DATA_OE, vecs[i].we);
      if (vecs[i].we) chk($sformatf("v%0d_data", i), DATA_BUS, vecs[i].bus_data);
      chk($sformatf("v%0d_ready", i), LOAD_READY, vecs[i].ready);
      chk($sformatf("v%0d_halt", i), HALT, 1);
      chk($sformatf("v%0d_count", i), WORD_COUNT, vecs[i].count);
      chk($sformatf("v%0d_sum", i), CHECKSUM, vecs[i].sum);
      tick();
    end

    // Full 12-word program, LAST on 0x000B
    do_reset();
    exp_sum = '0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 16'(i), prog[i], i == 11);
      chk($sformatf("prog%0d_ready", i), LOAD_READY, 1);
      exp_sum = exp_sum + prog[i];
      tick();
    end
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("prog_last_we", MEM_WE, 1);
    chk("prog_last_addr", ADDRESS_BUS, 16'h000B);
    chk("prog_last_data", DATA_BUS, 16'h4FFF);
    chk("prog_last_ready", LOAD_READY, 0);
    chk("prog_last_halt", HALT, 1);
    tick();
    chk("drain_we", MEM_WE, 0);
    chk("drain_doe", DATA_OE, 0);
    chk("drain_addr", ADDRESS_BUS, 16'h0000);
    chk("drain_ready", LOAD_READY, 0);
    chk("drain_halt", HALT, 1);
    tick();
    chk("run_halt", HALT, 0);
    chk("run_addr_oe", ADDR_OE, 0);
    chk("run_ready", LOAD_READY, 0);
    chk("run_count", WORD_COUNT, 12);
    chk("run_sum", CHECKSUM, exp_sum);
    tick();
    chk("run_hold_count", WORD_COUNT, 12);

    // Reboot from RUN, then single-word LAST image
    REBOOT = 1'b1;
    tick();
    REBOOT = 1'b0;
    chk("rb_halt", HALT, 1);
    chk("rb_addr_oe", ADDR_OE, 1);
    chk("rb_ready", LOAD_READY, 1);
    chk("rb_count", WORD_COUNT, 0);
    chk("rb_sum", CHECKSUM, 0);
    REBOOT = 1'b1;
    tick();
    REBOOT = 1'b0;
    chk("rb_in_load_ignored", LOAD_READY, 1);
    drive(1'b1, 16'h0000, 16'hF000, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("single_we", MEM_WE, 1);
    chk("single_data", DATA_BUS, 16'hF000);
    chk("single_ready", LOAD_READY, 0);
    tick();
    chk("single_drain_halt", HALT, 1);
    tick();
    chk("single_run_halt", HALT, 0);
    chk("single_count", WORD_COUNT, 1);
    chk("single_sum", CHECKSUM, 16'hF000);

    // Out-of-range address with MEM_DEPTH=256
    do_reset();
    drive(1'b1, 16'h0100, 16'h1234, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("err_we", MEM_WE, 0);
    chk("err_flag", LOAD_ERR, 1);
    chk("err_halt", HALT, 1);
    chk("err_ready", LOAD_READY, 0);
    chk("err_count", WORD_COUNT, 0);
    REBOOT = 1'b1;
    tick();
    REBOOT = 1'b0;
    tick();
    chk("err_reboot_ignored", LOAD_ERR, 1);
    chk("err_reboot_halt", HALT, 1);
    do_reset();
    chk("err_cleared", LOAD_ERR, 0);
    chk("err_cleared_ready", LOAD_READY, 1);

    // Boundary: highest legal address writes
    drive(1'b1, 16'h00FF, 16'h0042, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    chk("edge_we", MEM_WE, 1);
    chk("edge_addr", ADDRESS_BUS, 16'h00FF);
    chk("edge_err", LOAD_ERR, 0);

    // RESET during WRITE of word 2 (RESET also wins over REBOOT)
    do_reset();
    drive(1'b1, 16'h0030, 16'h0007, 1'b0);
    tick();
    drive(1'b1, 16'h0031, 16'h0008, 1'b0);
    tick();
    chk("w2_we", MEM_WE, 1);
    chk("w2_addr", ADDRESS_BUS, 16'h0031);
    RESET = 1'b1; REBOOT = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    tick();
    RESET = 1'b0; REBOOT = 1'b0;
    chk("rstw_we", MEM_WE, 0);
    chk("rstw_count", WORD_COUNT, 0);
    chk("rstw_sum", CHECKSUM, 0);
    chk("rstw_halt", HALT, 1);
    chk("rstw_ready", LOAD_READY, 1);
    tick();
    chk("rstw_no_write", MEM_WE, 0);
    chk("rstw_count2", WORD_COUNT, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bat_amateur_loader.md
# bat_amateur_loader

Synthesizable boot loader sitting directly upstream of the BatAmateur core and its unified 16-bit memory. After reset it holds the core in HALT and accepts a stream of (address, data) words over a valid/ready handshake. It writes each word into memory over the shared ADDRESS_BUS/DATA_BUS, then releases the buses and deasserts HALT so the core starts executing at address 0x0000. This replaces hand-driven bus stimulus with a real hardware stage.

## Interface
Parameters:
- ADDRESS_WIDTH, 16, width of ADDRESS_BUS and LOAD_ADDR
- DATA_WIDTH, 16, width of DATA_BUS and LOAD_DATA
- MEM_DEPTH, 65536, number of valid word addresses; LOAD_ADDR >= MEM_DEPTH is an error

Ports:
- CLK  input  1  system clock; all logic on rising edge
- RESET  input  1  synchronous, active-high reset
- LOAD_VALID  input  1  upstream word valid
- LOAD_READY  output  1  loader accepts a word this cycle
- LOAD_ADDR  input  ADDRESS_WIDTH  target memory address
- LOAD_DATA  input  DATA_WIDTH  word to write
- LOAD_LAST  input  1  marks final word of the image
- REBOOT  input  1  in RUN, return to LOAD and re-halt the core
- HALT  output  1  holds the core stopped
- ADDRESS_BUS  output  ADDRESS_WIDTH  memory address while loading
- ADDR_OE  output  1  loader drives ADDRESS_BUS
- DATA_BUS  output  DATA_WIDTH  write data (driven only when DATA_OE=1, else Z)
- DATA_OE  output  1  loader drives DATA_BUS
- MEM_WE  output  1  one-cycle memory write strobe
- WORD_COUNT  output  ADDRESS_WIDTH  words written since last reset/reboot (wraps)
- CHECKSUM  output  DATA_WIDTH  mod-2^DATA_WIDTH sum of written data
- LOAD_ERR  output  1  sticky out-of-range address error

## Operation
- States: LOAD, WRITE, DRAIN, RUN, ERROR.
- Reset (any state, any cycle) gives state LOAD, HALT=1, LOAD_READY=1, MEM_WE=0, ADDR_OE=1, DATA_OE=0, ADDRESS_BUS=0, WORD_COUNT=0, CHECKSUM=0, LOAD_ERR=0. An in-flight word is dropped.
- LOAD: a word is accepted on an edge with LOAD_VALID & LOAD_READY. The address, data and last flag are registered.
  - If LOAD_ADDR < MEM_DEPTH, go to WRITE.
  - Otherwise go to ERROR with no write.
- WRITE (one cycle): MEM_WE=1, DATA_OE=1, buses carry the registered word. WORD_COUNT+1 and CHECKSUM+=data at the closing edge.
  - LOAD_READY=1 in WRITE, so back-to-back words sustain one write per cycle. A new accept in WRITE stays in WRITE.
  - No accept and last flag clear: go to LOAD.
  - Last flag set: go to DRAIN. LOAD_READY is 0 in WRITE when the current word is last.
- DRAIN (one cycle): MEM_WE=0, DATA_OE=0, ADDRESS_BUS=0, LOAD_READY=0, HALT=1. Then go to RUN.
- RUN: HALT=0, ADDR_OE=0, DATA_OE=0, LOAD_READY=0, MEM_WE=0. WORD_COUNT and CHECKSUM are held.
  - REBOOT=1: go to LOAD next edge with HALT=1, ADDR_OE=1, and counters cleared.
- ERROR: HALT=1, LOAD_ERR=1, LOAD_READY=0, no bus drive except ADDR_OE=1 with ADDRESS_BUS=0. Exit only by RESET. REBOOT is ignored.
- REBOOT outside RUN is ignored.
- LOAD_LAST on the first word is legal (single-word image).

## Timing
- Accept at edge N gives MEM_WE=1 during cycle N→N+1, with ADDRESS_BUS/DATA_BUS valid the same cycle. Write latency is 1 cycle.
- Last word accepted at edge N: WRITE in N→N+1, DRAIN in N+1→N+2, HALT falls after edge N+2.
- Bus turnaround: DATA_OE is low for at least one full cycle (DRAIN) before HALT=0.
- WORD_COUNT/CHECKSUM update at the edge ending WRITE and are visible the next cycle.
- Simultaneous RESET and REBOOT: RESET wins.

## Structure
- Shared package bat_amateur_pkg holds the loader state enum, ADDRESS_WIDTH/DATA_WIDTH defaults, and the reset address constant 16'h0000.
- Single module with no sub-modules. The state register, word register and counters fit in one file.

## Test plan
- Reset, then stream (0x0010,0x0000), (0x0011,0x0001), (0x0012,0x0005) back-to-back with no gaps → three consecutive MEM_WE cycles at those addresses, WORD_COUNT=3, CHECKSUM=0x0006, HALT stays 1.
- Full 12-word program at 0x0000–0x000B (0x0012, 0x7F98, …, 0xF000, 0x4FFF), LAST on 0x000B → HALT=0 exactly 2 edges after last accept, DATA_OE=0 in DRAIN, WORD_COUNT=12.
- Gapped stream with LOAD_VALID low for 3 cycles between words → MEM_WE only on the cycle after each accept, state returns to LOAD, no spurious writes.
- MEM_DEPTH=256, word at address 0x0100 → no MEM_WE, LOAD_ERR=1, HALT=1. A later REBOOT has no effect, RESET clears LOAD_ERR.
- In RUN, pulse REBOOT → HALT=1 next cycle, WORD_COUNT=0, LOAD_READY=1. A single-word LAST image at 0x0000=0xF000 → HALT=0 two edges later.
- Assert RESET in the WRITE cycle of word 2 → no further MEM_WE, WORD_COUNT=0, HALT=1, LOAD_READY=1 next cycle.
